// File: rtl/func_bus_pkg.sv
// Shared definitions for the function-unit bus: flag width, reserved idle code,
// known unit codes and the reader FSM state encoding.
package func_bus_pkg;

  localparam int FLAG_W = 5;

  // No function unit may decode this code, so driving it leaves Y undriven.
  localparam logic [FLAG_W-1:0] IDLE_CODE = 5'b00000;

  // Codes of the function units currently attached to the bus.
  localparam logic [FLAG_W-1:0] FUNC_TRIG_A = 5'b11001;
  localparam logic [FLAG_W-1:0] FUNC_TRIG_B = 5'b11010;
  localparam logic [FLAG_W-1:0] FUNC_TRIG_C = 5'b11100;

  // Reader FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    DRIVE = ST_DRIVE,
    DONE  = ST_DONE
  } state_e;

  // Counter width able to hold 0..settle, never narrower than one bit.
  function automatic int settleWidth(input int settle);
    return (settle > 0) ? $clog2(settle + 1) : 1;
  endfunction

endpackage

// File: rtl/func_table_reader_settle_timer.sv
// Hold-time counter for one bus vector: counts SETTLE_CYCLES+1 enabled cycles,
// flags the last one with tc_o and then restarts from zero.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);
  import func_bus_pkg::*;

  localparam int            CW   = settleWidth(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  // Advance while enabled, wrap on the terminal count, clear takes priority.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/func_table_reader.sv
// Reader for the shared function-unit bus: selects one unit by its flag code,
// walks {A,B,C,D} through 0..15, samples Y per vector and compares the captured
// truth table against the expected one. All outputs come straight from flops.
module func_table_reader #(
  parameter int                             SETTLE_CYCLES = 2,
  parameter logic [func_bus_pkg::FLAG_W-1:0] IDLE_CODE    = func_bus_pkg::IDLE_CODE
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic [func_bus_pkg::FLAG_W-1:0]  func_sel_i,
  input  logic [15:0]                      exp_table_i,
  input  logic                             bus_y_i,
  output logic [func_bus_pkg::FLAG_W-1:0]  flag_o,
  output logic                             a_o,
  output logic                             b_o,
  output logic                             c_o,
  output logic                             d_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [15:0]                      result_table_o,
  output logic                             mismatch_o
);
  import func_bus_pkg::*;

  state_e state_q, state_d;

  logic [3:0]        idx_q, idx_d;
  logic [FLAG_W-1:0] code_q, code_d;
  logic [15:0]       exp_q, exp_d;
  logic [15:0]       result_q, result_d;
  logic              mismatch_q, mismatch_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic [3:0]        abcd_q, abcd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept;
  logic reject;
  logic aborting;
  logic sampleNow;
  logic tc;

  assign accept    = (state_q == IDLE) && start_i && (func_sel_i != IDLE_CODE);
  assign reject    = (state_q == IDLE) && start_i && (func_sel_i == IDLE_CODE);
  assign aborting  = (state_q == DRIVE) && abort_i;
  // An abort on the last hold cycle wins: that vector is not sampled.
  assign sampleNow = (state_q == DRIVE) && !abort_i && tc;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(accept || aborting),
    .en_i   ((state_q == DRIVE) && !abort_i),
    .tc_o   (tc)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: terminate only after index 15 has been sampled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = DRIVE;
      end
      DRIVE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (tc && (idx_q == 4'hF)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath next values, derived from the upcoming state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    idx_d      = idx_q;
    code_d     = code_q;
    exp_d      = exp_q;
    result_d   = result_q;
    mismatch_d = mismatch_q;

    if (accept) begin
      idx_d    = 4'd0;
      code_d   = func_sel_i;
      exp_d    = exp_table_i;
      result_d = '0;
    end else if (sampleNow) begin
      result_d[idx_q] = bus_y_i;
      idx_d           = idx_q + 4'd1;
    end

    flag_d = (state_d == DRIVE) ? code_d : IDLE_CODE;
    abcd_d = (state_d == DRIVE) ? idx_d : 4'd0;
    busy_d = (state_d == DRIVE) || (state_d == DONE);
    done_d = (state_d == DONE);
    err_d  = reject;

    if (state_d == DONE) begin
      mismatch_d = (result_d != exp_q);
    end
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q      <= 4'd0;
      code_q     <= IDLE_CODE;
      exp_q      <= '0;
      result_q   <= '0;
      mismatch_q <= 1'b0;
      flag_q     <= IDLE_CODE;
      abcd_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      code_q     <= code_d;
      exp_q      <= exp_d;
      result_q   <= result_d;
      mismatch_q <= mismatch_d;
      flag_q     <= flag_d;
      abcd_q     <= abcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign flag_o         = flag_q;
  assign a_o            = abcd_q[3];
  assign b_o            = abcd_q[2];
  assign c_o            = abcd_q[1];
  assign d_o            = abcd_q[0];
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign result_table_o = result_q;
  assign mismatch_o     = mismatch_q;

endmodule

// File: tb/tb_func_table_reader.sv
// Bench for func_table_reader: two readers (settle 1 and settle 0) each see a
// model of unit 5'b11001 on their own Y line. Completed sweeps are predicted in
// a scoreboard queue and checked by a monitor whenever done is seen.
module tb_func_table_reader;
  import func_bus_pkg::*;

  typedef struct packed {
    logic [15:0] result;
    logic        mism;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int assertions = 0;
  int failures   = 0;
  int doneCount  = 0;

  exp_t sbQ[$];

  // Truth table of the modelled unit: a fixed, hand-chosen function.
  logic [15:0] unitTable = 16'h0AB7;

  // Reader with one extra settle cycle.
  logic             start, abort;
  logic [FLAG_W-1:0] funcSel, flag;
  logic [15:0]      expTable, resultTable;
  logic             a, b, c, d, busy, done, err, mismatch;
  logic [3:0]       idx;
  wire              busY;

  // Reader with no extra settle cycle.
  logic             start0, abort0;
  logic [FLAG_W-1:0] funcSel0, flag0;
  logic [15:0]      expTable0, resultTable0;
  logic             a0, b0, c0w, d0, busy0, done0, err0, mismatch0;
  logic [3:0]       idx0;
  wire              busY0;

  assign idx  = {a, b, c, d};
  assign idx0 = {a0, b0, c0w, d0};

  // The unit answers only when its own code is on the flag lines.
  assign busY  = (flag  == FUNC_TRIG_A) ? unitTable[idx]  : 1'bz;
  assign busY0 = (flag0 == FUNC_TRIG_A) ? unitTable[idx0] : 1'bz;

  func_table_reader #(.SETTLE_CYCLES(1), .IDLE_CODE(IDLE_CODE)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .func_sel_i(funcSel), .exp_table_i(expTable), .bus_y_i(busY),
    .flag_o(flag), .a_o(a), .b_o(b), .c_o(c), .d_o(d),
    .busy_o(busy), .done_o(done), .err_o(err),
    .result_table_o(resultTable), .mismatch_o(mismatch)
  );

  func_table_reader #(.SETTLE_CYCLES(0), .IDLE_CODE(IDLE_CODE)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .abort_i(abort0),
    .func_sel_i(funcSel0), .exp_table_i(expTable0), .bus_y_i(busY0),
    .flag_o(flag0), .a_o(a0), .b_o(b0), .c_o(c0w), .d_o(d0),
    .busy_o(busy0), .done_o(done0), .err_o(err0),
    .result_table_o(resultTable0), .mismatch_o(mismatch0)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Cycle number: cycle n is the interval after the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance to #1 after the edge that begins cycle t.
  task automatic waitUntil(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start one sweep on the settle-1 reader; returns the cycle start was high in.
  task automatic applyStimulus(input logic [FLAG_W-1:0] sel, input logic [15:0] expT,
                               input int holdCycles, output int c0);
    start    = 1'b1;
    funcSel  = sel;
    expTable = expT;
    c0       = cyc;
    waitUntil(c0 + holdCycles);
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest prediction; while a sweep
  // is being driven the selected unit must be the one answering on Y.
  always @(negedge clk) begin
    if (!rst && done) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("done_cycle", cyc, e.cyc);
        checkOutput("result_table", {16'h0, resultTable}, {16'h0, e.result});
        checkOutput("mismatch", {31'h0, mismatch}, {31'h0, e.mism});
        checkOutput("done_flag_idle", {27'h0, flag}, {27'h0, IDLE_CODE});
        checkOutput("done_abcd_zero", {28'h0, idx}, 32'h0);
        checkOutput("done_busy", {31'h0, busy}, 32'h1);
      end
    end else if (!rst && busy) begin
      checkOutput("drive_flag", {27'h0, flag}, {27'h0, FUNC_TRIG_A});
      checkOutput("bus_y_known", {31'h0, $isunknown(busY)}, 32'h0);
    end
  end

  // Directed test sequence.
  initial begin
    int c0;
    int c1;
    int doneBefore;

    start = 0; abort = 0; funcSel = IDLE_CODE; expTable = '0;
    start0 = 0; abort0 = 0; funcSel0 = IDLE_CODE; expTable0 = '0;

    waitUntil(3);
    checkOutput("rst_flag", {27'h0, flag}, {27'h0, IDLE_CODE});
    checkOutput("rst_abcd", {28'h0, idx}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_result", {16'h0, resultTable}, 32'h0);
    checkOutput("rst_mismatch", {31'h0, mismatch}, 32'h0);
    rst = 1'b0;
    waitUntil(5);

    // Matching table: done 33 cycles after start.
    applyStimulus(FUNC_TRIG_A, 16'h0AB7, 1, c0);
    sbQ.push_back('{result: 16'h0AB7, mism: 1'b0, cyc: c0 + 33});
    checkOutput("t1_busy_first", {31'h0, busy}, 32'h1);
    waitUntil(c0 + 34);
    checkOutput("t1_busy_after", {31'h0, busy}, 32'h0);
    checkOutput("t1_result_hold", {16'h0, resultTable}, 32'h0AB7);

    // One bit different in the expected table.
    applyStimulus(FUNC_TRIG_A, 16'h0AB6, 1, c0);
    sbQ.push_back('{result: 16'h0AB7, mism: 1'b1, cyc: c0 + 33});
    waitUntil(c0 + 34);
    checkOutput("t2_mismatch_hold", {31'h0, mismatch}, 32'h1);

    // Abort while vector 5 is driven (cycles 11..12 with one settle cycle).
    applyStimulus(FUNC_TRIG_A, 16'h0AB7, 1, c0);
    waitUntil(c0 + 11);
    checkOutput("t4_abcd_before", {28'h0, idx}, 32'h5);
    abort = 1'b1;
    waitUntil(c0 + 12);
    abort = 1'b0;
    checkOutput("t4_flag_idle", {27'h0, flag}, {27'h0, IDLE_CODE});
    checkOutput("t4_busy", {31'h0, busy}, 32'h0);
    checkOutput("t4_abcd", {28'h0, idx}, 32'h0);
    checkOutput("t4_partial", {16'h0, resultTable}, 32'h0017);
    checkOutput("t4_mismatch_kept", {31'h0, mismatch}, 32'h1);
    applyStimulus(FUNC_TRIG_A, 16'hFFFF, 1, c1);
    sbQ.push_back('{result: 16'h0AB7, mism: 1'b1, cyc: c1 + 33});
    checkOutput("t4_restart_busy", {31'h0, busy}, 32'h1);
    waitUntil(c1 + 34);

    // Reset together with abort in mid-sweep.
    applyStimulus(FUNC_TRIG_A, 16'h0AB7, 1, c0);
    waitUntil(c0 + 9);
    rst = 1'b1;
    abort = 1'b1;
    waitUntil(c0 + 10);
    checkOutput("t5_flag", {27'h0, flag}, {27'h0, IDLE_CODE});
    checkOutput("t5_abcd", {28'h0, idx}, 32'h0);
    checkOutput("t5_busy", {31'h0, busy}, 32'h0);
    checkOutput("t5_done", {31'h0, done}, 32'h0);
    checkOutput("t5_err", {31'h0, err}, 32'h0);
    checkOutput("t5_result", {16'h0, resultTable}, 32'h0);
    checkOutput("t5_mismatch", {31'h0, mismatch}, 32'h0);
    rst = 1'b0;
    abort = 1'b0;
    waitUntil(c0 + 12);

    // Start with the idle code is rejected.
    applyStimulus(IDLE_CODE, 16'h0AB7, 1, c0);
    checkOutput("t6_err_pulse", {31'h0, err}, 32'h1);
    checkOutput("t6_err_busy", {31'h0, busy}, 32'h0);
    waitUntil(c0 + 2);
    checkOutput("t6_err_clear", {31'h0, err}, 32'h0);
    checkOutput("t6_err_busy2", {31'h0, busy}, 32'h0);

    // Start held high through the whole sweep gives a single done.
    doneBefore = doneCount;
    applyStimulus(FUNC_TRIG_A, 16'h0AB7, 33, c0);
    sbQ.push_back('{result: 16'h0AB7, mism: 1'b0, cyc: c0 + 33});
    waitUntil(c0 + 45);
    checkOutput("t6_single_done", doneCount - doneBefore, 32'd1);
    checkOutput("t6_idle_after", {31'h0, busy}, 32'h0);

    // No settle cycles: one index per cycle, done 17 cycles after start.
    start0 = 1'b1; funcSel0 = FUNC_TRIG_A; expTable0 = 16'h0AB7;
    c0 = cyc;
    waitUntil(c0 + 1);
    start0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      waitUntil(c0 + 1 + k);
      checkOutput($sformatf("t3_idx%0d", k), {28'h0, idx0}, k);
      checkOutput($sformatf("t3_flag%0d", k), {27'h0, flag0}, {27'h0, FUNC_TRIG_A});
    end
    waitUntil(c0 + 17);
    checkOutput("t3_done", {31'h0, done0}, 32'h1);
    checkOutput("t3_flag_idle", {27'h0, flag0}, {27'h0, IDLE_CODE});
    checkOutput("t3_result", {16'h0, resultTable0}, 32'h0AB7);
    checkOutput("t3_mismatch", {31'h0, mismatch0}, 32'h0);
    waitUntil(c0 + 18);
    checkOutput("t3_done_pulse", {31'h0, done0}, 32'h0);

    checkOutput("scoreboard_empty", sbQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
